// File: rtl/clk_seq_pkg.sv
// Purpose : shared encodings and widths for the clock-lock sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state encodings (also the value seen on the debug state port),
// state/retry widths, and a small helper that sizes the shared timer.
package clk_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  // Encodings are visible on the debug port, so keep them fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_WIZ = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Largest of three phase lengths; the one timer is shared by all phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_lock_sequencer_sync_2ff.sv
// Purpose : two-flop synchronizer bringing one asynchronous bit into clk.
// Latency : q_o follows d_i after 2 clk edges.
// Backpressure: none; every clk edge samples d_i.
//
// Ports: clk (clock), rst_n (async active-low, clears both flops to 0),
//        d_i (asynchronous input), q_o (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_lock_sequencer.sv
// Purpose : brings up a clocking wizard (reset pulse, lock wait, lock
//           qualification) and gates the datapath enable; retries, then faults.
// Latency : all outputs registered, updating on the same edge as state;
//           locked is seen 2 edges late through the synchronizer.
// Backpressure: none; start is a level, start=0 returns to IDLE next edge.
//
// Ports: clk, reset_n (async active-low), start (level run request),
//        locked (async wizard lock), wiz_reset (active-high wizard reset),
//        run_enable (high only in RUN), fault (sticky until start=0),
//        state (debug encoding), retry_cnt (retries used this session).
module clk_lock_sequencer
  import clk_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               locked,
  output logic               wiz_reset,
  output logic               run_enable,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int TMR_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               wiz_reset_q, wiz_reset_d;
  logic               run_enable_q, run_enable_d;
  logic               fault_q, fault_d;
  logic               do_retry;
  logic               locked_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // State register plus the counters and registered outputs that move with it.
  // wiz_reset resets high so the wizard is held in reset as soon as reset_n drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      wiz_reset_q  <= 1'b1;
      run_enable_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      wiz_reset_q  <= wiz_reset_d;
      run_enable_q <= run_enable_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state logic. The timer is cleared on every transition and held at
  // zero in the phases that do not time anything, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    do_retry = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d = ST_RESET_WIZ;
          retry_d = '0;
        end
      end
      ST_RESET_WIZ: begin
        if (timer_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          do_retry = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_STABLE: begin
        // Any single unlocked cycle disqualifies the attempt.
        if (!locked_s) begin
          do_retry = 1'b1;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_RUN: begin
        timer_d = '0;
        if (!locked_s) begin
          do_retry = 1'b1;
        end
      end
      ST_FAULT: begin
        timer_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        retry_d = '0;
      end
    endcase

    // Retry decision shared by timeout, unstable lock and lock loss.
    // The counter stops at the limit because reaching it diverts to FAULT.
    if (do_retry) begin
      timer_d = '0;
      if (retry_q == RETRY_LAST) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + RETRY_ONE;
        state_d = ST_RESET_WIZ;
      end
    end

    // Dropping start wins over every other transition.
    if (!start && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      timer_d = '0;
      retry_d = '0;
    end
  end

  // Output decode from the next state, so registered outputs and state
  // change together on the same edge.
  always_comb begin
    wiz_reset_d  = (state_d == ST_IDLE) || (state_d == ST_RESET_WIZ) ||
                   (state_d == ST_FAULT);
    run_enable_d = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  assign wiz_reset  = wiz_reset_q;
  assign run_enable = run_enable_q;
  assign fault      = fault_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Bench for clk_lock_sequencer: directed bring-up scenarios followed by a
// random start/locked phase, every cycle compared against a phase model.
module tb_clk_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 16;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       locked;
  logic       wiz_reset;
  logic       run_enable;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  clk_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .locked     (locked),
    .wiz_reset  (wiz_reset),
    .run_enable (run_enable),
    .fault      (fault),
    .state      (state),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycles elapsed in the phase, retries used,
  // and a two-deep history of locked as the synchronizer would see it.
  int m_ph = 0;
  int m_el = 0;
  int m_rt = 0;
  bit m_h1 = 1'b0;
  bit m_h2 = 1'b0;

  task automatic go(input int ph);
    m_ph = ph;
    m_el = 0;
  endtask

  task automatic m_retry();
    if (m_rt >= MAX_RETRIES) go(5);
    else begin
      m_rt = m_rt + 1;
      go(1);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_rt = 0; m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit lk);
    bit ls;
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = lk;
    if (m_ph != 0 && !st) begin
      go(0);
      m_rt = 0;
    end else begin
      case (m_ph)
        0: if (st) begin go(1); m_rt = 0; end
        1: if (m_el + 1 >= RST_CYCLES) go(2); else m_el++;
        2: if (ls) go(3);
           else if (m_el + 1 >= LOCK_TIMEOUT) m_retry();
           else m_el++;
        3: if (!ls) m_retry();
           else if (m_el + 1 >= STABLE_CYCLES) go(4);
           else m_el++;
        4: if (!ls) m_retry();
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, ncyc, obs, exp);
    end
  endtask

  // Compare all outputs against the model: {state, wiz, run, fault, retry}.
  task automatic chk_model();
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    exp_v = {3'(m_ph), (m_ph == 0 || m_ph == 1 || m_ph == 5), (m_ph == 4),
             (m_ph == 5), 4'(m_rt)};
    obs_v = {state, wiz_reset, run_enable, fault, retry_cnt};
    chk("model", 16'(obs_v), 16'(exp_v));
  endtask

  task automatic step(input bit st, input bit lk);
    start  = st;
    locked = lk;
    @(posedge clk);
    #1;
    ncyc++;
    model_step(st, lk);
    chk_model();
  endtask

  initial begin
    int n_rw, wiz_fall, run_rise, drop_at, saw_stable, saw_run;
    int lk_left, st_left;
    bit lk_v, st_v;

    // ---- reset values
    reset_n = 1'b0; start = 1'b0; locked = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_wiz", 16'(wiz_reset), 16'd1);
    chk("rst_run", 16'(run_enable), 16'd0);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_retry", 16'(retry_cnt), 16'd0);
    reset_n = 1'b1;
    model_reset();
    #2;

    // ---- nominal bring-up: locked seen from step 8 on
    n_rw = 0; wiz_fall = 0; run_rise = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, k >= 8);
      if (state == 3'd1) n_rw++;
      if (wiz_fall == 0 && wiz_reset === 1'b0) wiz_fall = k;
      if (run_rise == 0 && run_enable === 1'b1) run_rise = k;
    end
    chk("nom_rstwiz_len", 16'(n_rw), 16'd4);
    chk("nom_wiz_fall", 16'(wiz_fall), 16'd5);
    chk("nom_run_lag", 16'(run_rise - 8), 16'd10);
    chk("nom_retry", 16'(retry_cnt), 16'd0);
    chk("nom_fault", 16'(fault), 16'd0);

    // ---- lock loss in RUN for 5 cycles, then relock
    drop_at = 0;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0);
      if (drop_at == 0 && run_enable === 1'b0) drop_at = k;
    end
    chk("loss_drop_lag", 16'(drop_at), 16'd3);
    chk("loss_retry", 16'(retry_cnt), 16'd1);
    for (int k = 1; k <= 25; k++) step(1'b1, 1'b1);
    chk("relock_state", 16'(state), 16'd4);
    chk("relock_run", 16'(run_enable), 16'd1);
    chk("relock_retry", 16'(retry_cnt), 16'd1);

    // ---- async reset mid-RUN, checked between clock edges
    #3 reset_n = 1'b0;
    #1;
    chk("arst_run", 16'(run_enable), 16'd0);
    chk("arst_wiz", 16'(wiz_reset), 16'd1);
    chk("arst_state", 16'(state), 16'd0);
    model_reset();
    #2 reset_n = 1'b1;
    step(1'b0, 1'b0);
    chk("arst_idle", 16'(state), 16'd0);

    // ---- abort in WAIT_LOCK
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0);
    chk("abort_pre", 16'(state), 16'd2);
    step(1'b0, 1'b0);
    chk("abort_wl_state", 16'(state), 16'd0);
    chk("abort_wl_wiz", 16'(wiz_reset), 16'd1);
    chk("abort_wl_retry", 16'(retry_cnt), 16'd0);

    // ---- unstable lock: 4 cycles high then low while qualifying
    saw_stable = 0; saw_run = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, (k >= 6 && k <= 9));
      if (state == 3'd3) saw_stable = 1;
      if (run_enable === 1'b1) saw_run = 1;
    end
    chk("unst_saw_stable", 16'(saw_stable), 16'd1);
    chk("unst_no_run", 16'(saw_run), 16'd0);
    chk("unst_retry", 16'(retry_cnt), 16'd1);
    step(1'b0, 1'b0);

    // ---- timeout: three attempts of 4+16 cycles, then FAULT
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b0);
      if (k == 20) chk("to_a1_wait", 16'(state), 16'd2);
      if (k == 21) chk("to_a2_retry", 16'({state, retry_cnt}), 16'h11);
      if (k == 41) chk("to_a3_retry", 16'({state, retry_cnt}), 16'h12);
      if (k == 60) chk("to_a3_wait", 16'(state), 16'd2);
      if (k == 61) chk("to_fault_state", 16'(state), 16'd5);
    end
    chk("to_fault", 16'(fault), 16'd1);
    chk("to_fault_wiz", 16'(wiz_reset), 16'd1);
    chk("to_fault_retry", 16'(retry_cnt), 16'd2);
    step(1'b0, 1'b0);
    chk("abort_f_state", 16'(state), 16'd0);
    chk("abort_f_fault", 16'(fault), 16'd0);
    chk("abort_f_retry", 16'(retry_cnt), 16'd0);
    chk("abort_f_wiz", 16'(wiz_reset), 16'd1);

    // ---- random locked bursts and occasional start drops
    lk_v = 1'b0; st_v = 1'b1; lk_left = 0; st_left = 0;
    for (int k = 0; k < 3000; k++) begin
      if (lk_left == 0) begin
        lk_v = ~lk_v;
        lk_left = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 80)
                                               : $urandom_range(1, 20);
      end
      if (st_left == 0) begin
        if (st_v) begin
          st_v = ($urandom_range(0, 149) != 0);
          st_left = st_v ? 0 : $urandom_range(1, 3);
        end else begin
          st_v = 1'b1;
        end
      end
      step(st_v, lk_v);
      lk_left--;
      if (st_left > 0) st_left--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
